// File: rtl/ddr3_ctrl_pkg.sv
// Shared types for the DDR3 read/write burst controller.
package ddr3_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        WRITE = 2'd2,
        READ  = 2'd3
    } state_t;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin index picker: first requester strictly after 'last', wrapping.
module rr_arbiter
    import ddr3_ctrl_pkg::*;
#(
    parameter  int N = 2,
    localparam int W = ch_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] grant,
    output logic         valid
);

    // Descending scan so the closest channel after 'last' is the one left standing.
    always_comb begin
        grant = last;
        valid = 1'b0;
        for (int i = N; i >= 1; i--) begin
            if (req[(int'(last) + i) % N]) begin
                grant = W'((int'(last) + i) % N);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr3_mc_rw_ctrl.sv
// Multi-channel DDR3 burst scheduler: writes before reads, round-robin within each class.
// Define DDR3_PINGPANG_EN to substitute a per-channel page bit at address bit PAGE_BIT.
module ddr3_mc_rw_ctrl
    import ddr3_ctrl_pkg::*;
#(
    parameter  int CH_NUM   = 2,
    parameter  int ADDR_W   = 28,
    parameter  int LEN_W    = 10,
    parameter  int CNT_W    = 11,
    parameter  int PAGE_BIT = 24,
    localparam int CH_W     = ch_width(CH_NUM)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ddr3_init_done,
    input  logic [CH_NUM*ADDR_W-1:0] wd_addr_min,
    input  logic [CH_NUM*ADDR_W-1:0] wd_addr_max,
    input  logic [CH_NUM*ADDR_W-1:0] rd_addr_min,
    input  logic [CH_NUM*ADDR_W-1:0] rd_addr_max,
    input  logic [LEN_W-1:0]         wd_burst_len,
    input  logic [LEN_W-1:0]         rd_burst_len,
    input  logic [CH_NUM*CNT_W-1:0]  wfifo_rcount,
    input  logic [CH_NUM*CNT_W-1:0]  rfifo_wcount,
    input  logic [CH_NUM-1:0]        wr_load,
    input  logic [CH_NUM-1:0]        rd_load,
    input  logic                     wd_finish,
    input  logic                     rd_finish,
    output logic                     wd_req,
    output logic                     rd_req,
    output logic [ADDR_W-1:0]        wd_addr,
    output logic [ADDR_W-1:0]        rd_addr,
    output logic [LEN_W-1:0]         wd_len,
    output logic [LEN_W-1:0]         rd_len,
    output logic [CH_W-1:0]          wd_ch,
    output logic [CH_W-1:0]          rd_ch,
    output logic [CH_NUM-1:0]        frame_done
);

    if (CH_NUM < 1 || CH_NUM > 4 || PAGE_BIT >= ADDR_W) begin : g_bad_cfg
        $error("ddr3_mc_rw_ctrl: unsupported parameter set");
    end

    state_t state, state_nxt;
    logic [CH_W-1:0] wch, rch, w_last, r_last, w_gnt, r_gnt;
    logic            w_vld, r_vld, w_take, r_take, w_done, r_done;
    logic [CH_NUM-1:0] w_elig, r_elig, w_wrap, r_wrap;
    logic [CH_NUM-1:0][ADDR_W-1:0] wa_out, ra_out;

    rr_arbiter #(.N(CH_NUM)) u_warb (.req(w_elig), .last(w_last), .grant(w_gnt), .valid(w_vld));
    rr_arbiter #(.N(CH_NUM)) u_rarb (.req(r_elig), .last(r_last), .grant(r_gnt), .valid(r_vld));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        w_take    = 1'b0;
        r_take    = 1'b0;
        w_done    = 1'b0;
        r_done    = 1'b0;
        case (state)
            IDLE:  if (ddr3_init_done) state_nxt = ARB;
            ARB: begin
                if (w_vld) begin
                    state_nxt = WRITE;
                    w_take    = 1'b1;
                end else if (r_vld) begin
                    state_nxt = READ;
                    r_take    = 1'b1;
                end
            end
            WRITE: if (wd_finish) begin
                state_nxt = ARB;
                w_done    = 1'b1;
            end
            READ:  if (rd_finish) begin
                state_nxt = ARB;
                r_done    = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wch        <= '0;
            rch        <= '0;
            w_last     <= CH_W'(CH_NUM - 1);
            r_last     <= CH_W'(CH_NUM - 1);
            wd_req     <= 1'b0;
            rd_req     <= 1'b0;
            wd_addr    <= '0;
            rd_addr    <= '0;
            wd_len     <= '0;
            rd_len     <= '0;
            wd_ch      <= '0;
            rd_ch      <= '0;
            frame_done <= '0;
        end else begin
            frame_done <= '0;
            if (w_take) begin
                wch    <= w_gnt;
                w_last <= w_gnt;
            end
            if (r_take) begin
                rch    <= r_gnt;
                r_last <= r_gnt;
            end
            // Request drops on the same edge that samples finish.
            wd_req <= (state == WRITE) && !wd_finish;
            rd_req <= (state == READ) && !rd_finish;
            if (state == WRITE) begin
                wd_addr <= wa_out[wch];
                wd_len  <= wd_burst_len;
                wd_ch   <= wch;
            end
            if (state == READ) begin
                rd_addr <= ra_out[rch];
                rd_len  <= rd_burst_len;
                rd_ch   <= rch;
            end
            if (w_done) frame_done[wch] <= w_wrap[wch];
        end
    end

    for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
        // Addresses are held as offsets from min so reset needs no dynamic load value.
        logic [ADDR_W-1:0] w_off, r_off, wa_cur, ra_cur;
        logic [ADDR_W:0]   w_sum, r_sum;
        logic [2:0]        wl_sync, rl_sync;
        logic              wl_edge, rl_edge, wl_pend, rl_pend, rd_seen;

        assign wl_edge   = wl_sync[1] & ~wl_sync[2];
        assign rl_edge   = rl_sync[1] & ~rl_sync[2];
        assign wa_cur    = wd_addr_min[k*ADDR_W +: ADDR_W] + w_off;
        assign ra_cur    = rd_addr_min[k*ADDR_W +: ADDR_W] + r_off;
        assign w_sum     = {1'b0, wa_cur} + (ADDR_W+1)'(wd_burst_len);
        assign r_sum     = {1'b0, ra_cur} + (ADDR_W+1)'(rd_burst_len);
        assign w_wrap[k] = w_sum >= {1'b0, wd_addr_max[k*ADDR_W +: ADDR_W]};
        assign r_wrap[k] = r_sum >= {1'b0, rd_addr_max[k*ADDR_W +: ADDR_W]};
        assign w_elig[k] = 32'(wfifo_rcount[k*CNT_W +: CNT_W]) >= 32'(wd_burst_len);
        assign r_elig[k] = rd_seen && (32'(rfifo_wcount[k*CNT_W +: CNT_W]) < 32'(rd_burst_len));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                w_off   <= '0;
                r_off   <= '0;
                wl_sync <= '0;
                rl_sync <= '0;
                wl_pend <= 1'b0;
                rl_pend <= 1'b0;
                rd_seen <= 1'b0;
            end else begin
                wl_sync <= {wl_sync[1:0], wr_load[k]};
                rl_sync <= {rl_sync[1:0], rd_load[k]};
                if (rl_edge) rd_seen <= 1'b1;
                // Loads wait for ARB, so an in-flight burst advances first and is then overridden.
                if (state == ARB && (wl_pend || wl_edge)) begin
                    w_off   <= '0;
                    wl_pend <= 1'b0;
                end else begin
                    if (wl_edge) wl_pend <= 1'b1;
                    if (w_done && wch == CH_W'(k))
                        w_off <= w_wrap[k] ? '0 : w_off + ADDR_W'(wd_burst_len);
                end
                if (state == ARB && (rl_pend || rl_edge)) begin
                    r_off   <= '0;
                    rl_pend <= 1'b0;
                end else begin
                    if (rl_edge) rl_pend <= 1'b1;
                    if (r_done && rch == CH_W'(k))
                        r_off <= r_wrap[k] ? '0 : r_off + ADDR_W'(rd_burst_len);
                end
            end
        end

`ifdef DDR3_PINGPANG_EN
        logic wpage, rpage;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wpage <= 1'b0;
                rpage <= 1'b0;
            end else begin
                if (w_done && wch == CH_W'(k) && w_wrap[k]) wpage <= ~wpage;
                // Reader takes the page the writer is not filling.
                if (rl_edge) rpage <= ~wpage;
            end
        end

        always_comb begin
            wa_out[k]           = wa_cur;
            wa_out[k][PAGE_BIT] = wpage;
            ra_out[k]           = ra_cur;
            ra_out[k][PAGE_BIT] = rpage;
        end
`else
        assign wa_out[k] = wa_cur;
        assign ra_out[k] = ra_cur;
`endif
    end

endmodule
